// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_DEF = 1023;

    // grant_id width; never below one bit so a two-client build still has a port.
    function automatic int gid_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester after last, with wrap.
module rr_pick #(
    parameter int N  = 3,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] last_i,
    output logic [GW-1:0] winner_o,
    output logic          any_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        winner_o = '0;
        any_o    = 1'b0;
        // The last winner is visited at i == N, so it only wins when it is alone.
        for (int i = 1; i <= N; i++) begin
            if (!any_o && req_i[(int'(last_i) + i) % N]) begin
                winner_o = GW'((int'(last_i) + i) % N);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of one toggle-handshake SDRAM port among N level-request clients.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N       = 3,
    parameter int AW      = 15,
    parameter int TIMEOUT = TIMEOUT_DEF,
    localparam int GW     = gid_w(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    cli_req,
    input  logic [N-1:0]    cli_we,
    input  logic [N*AW-1:0] cli_a,
    input  logic [N*16-1:0] cli_d,
    input  logic [N*2-1:0]  cli_be,
    output logic [N-1:0]    cli_done,
    output logic [15:0]     cli_q,
    output logic [GW-1:0]   grant_id,
    output logic            busy,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic            mem_we,
    output logic [AW-1:0]   mem_a,
    output logic [15:0]     mem_d,
    output logic            mem_u_n,
    output logic            mem_l_n,
    input  logic [15:0]     mem_q,
    output logic            timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] a_q, a_d;
    logic [15:0]   d_q, d_d;
    logic [1:0]    be_n_q, be_n_d;
    logic [N-1:0]  done_q, done_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [GW-1:0] winner;
    logic          any;

    // grant_q doubles as the round-robin "last" pointer.
    rr_pick #(.N(N), .GW(GW)) u_pick (
        .req_i    (cli_req),
        .last_i   (grant_q),
        .winner_o (winner),
        .any_o    (any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        req_d   = req_q;
        we_d    = we_q;
        a_d     = a_q;
        d_d     = d_q;
        be_n_d  = be_n_q;
        done_d  = '0;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    we_d    = cli_we[winner];
                    a_d     = cli_a[int'(winner)*AW +: AW];
                    d_d     = cli_d[int'(winner)*16 +: 16];
                    be_n_d  = ~cli_be[int'(winner)*2 +: 2];
                    req_d   = ~req_q;
                    grant_d = winner;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack == req_q) begin
                    if (!we_q) rdata_d = mem_q;
                    done_d[grant_q] = 1'b1;
                    state_d         = DONE;
                end else begin
                    if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
                    // Late ack is only flagged; the transfer keeps waiting for the real ack.
                    if (cnt_d == CW'(TIMEOUT)) err_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            req_q   <= mem_ack;  // resynchronise the toggle pair after a mid-transfer reset
            we_q    <= 1'b0;
            a_q     <= '0;
            d_q     <= '0;
            be_n_q  <= 2'b11;
            done_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            req_q   <= req_d;
            we_q    <= we_d;
            a_q     <= a_d;
            d_q     <= d_d;
            be_n_q  <= be_n_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign cli_done    = done_q;
    assign cli_q       = rdata_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_a       = a_q;
    assign mem_d       = d_q;
    assign mem_u_n     = be_n_q[1];
    assign mem_l_n     = be_n_q[0];
    assign timeout_err = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (N=3, AW=15, TIMEOUT=1023).
module tb_sdram_port_arbiter;

    localparam int N       = 3;
    localparam int AW      = 15;
    localparam int TIMEOUT = 1023;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cli_req;
    logic [N-1:0]    cli_we;
    logic [N*AW-1:0] cli_a;
    logic [N*16-1:0] cli_d;
    logic [N*2-1:0]  cli_be;
    logic [N-1:0]    cli_done;
    logic [15:0]     cli_q;
    logic [1:0]      grant_id;
    logic            busy;
    logic            mem_req;
    logic            mem_ack;
    logic            mem_we;
    logic [AW-1:0]   mem_a;
    logic [15:0]     mem_d;
    logic            mem_u_n;
    logic            mem_l_n;
    logic [15:0]     mem_q;
    logic            timeout_err;

    int tests = 0;
    int fails = 0;
    logic req_model;

    sdram_port_arbiter #(.N(N), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .cli_req     (cli_req),
        .cli_we      (cli_we),
        .cli_a       (cli_a),
        .cli_d       (cli_d),
        .cli_be      (cli_be),
        .cli_done    (cli_done),
        .cli_q       (cli_q),
        .grant_id    (grant_id),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_we      (mem_we),
        .mem_a       (mem_a),
        .mem_d       (mem_d),
        .mem_u_n     (mem_u_n),
        .mem_l_n     (mem_l_n),
        .mem_q       (mem_q),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        cli_req = '0;
        cli_we  = '0;
        cli_a   = '0;
        cli_d   = '0;
        cli_be  = '0;
        mem_ack = 1'b1;
        mem_q   = '0;
        repeat (3) tick();
        reset = 1'b0;
        req_model = 1'b1;

        // Reset state
        check("rst_mem_req", 32'(mem_req), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(cli_done), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_un_ln", 32'({mem_u_n, mem_l_n}), 32'b11);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_cli_q", 32'(cli_q), 32'd0);

        // Client 0 read: mem_req toggles 1 -> 0
        cli_req = 3'b001;
        cli_a[0*AW +: AW] = 15'h0011;
        cli_be[1:0] = 2'b11;
        tick();
        req_model = ~req_model;
        check("c0_mem_req", 32'(mem_req), 32'd0);
        check("c0_busy", 32'(busy), 32'd1);
        check("c0_grant", 32'(grant_id), 32'd0);
        check("c0_mem_a", 32'(mem_a), 32'h0011);
        check("c0_mem_we", 32'(mem_we), 32'd0);
        mem_ack = req_model;
        mem_q   = 16'h1111;
        tick();
        check("c0_done", 32'(cli_done), 32'b001);
        check("c0_cli_q", 32'(cli_q), 32'h1111);
        cli_req = 3'b000;
        tick();
        check("c0_done_end", 32'(cli_done), 32'b000);
        tick();
        check("c0_idle", 32'(busy), 32'd0);

        // Client 1 write with upper byte only, ack 3 cycles later
        cli_req = 3'b010;
        cli_we  = 3'b010;
        cli_a[1*AW +: AW] = 15'h1234;
        cli_d[1*16 +: 16] = 16'hBEEF;
        cli_be[3:2] = 2'b10;
        tick();
        req_model = ~req_model;
        check("c1_mem_a", 32'(mem_a), 32'h1234);
        check("c1_mem_d", 32'(mem_d), 32'hBEEF);
        check("c1_u_n", 32'(mem_u_n), 32'd0);
        check("c1_l_n", 32'(mem_l_n), 32'd1);
        check("c1_we", 32'(mem_we), 32'd1);
        check("c1_mem_req", 32'(mem_req), 32'(req_model));
        check("c1_grant", 32'(grant_id), 32'd1);
        tick();
        check("c1_wait1", 32'(cli_done), 32'b000);
        tick();
        check("c1_wait2", 32'(cli_done), 32'b000);
        mem_ack = req_model;
        tick();
        check("c1_done", 32'(cli_done), 32'b010);
        check("c1_cli_q_kept", 32'(cli_q), 32'h1111);
        cli_req = 3'b000;
        cli_we  = 3'b000;
        tick();
        tick();

        // Client 2 alone, twice back-to-back with cli_req held
        cli_req = 3'b100;
        cli_a[2*AW +: AW] = 15'h0222;
        cli_be[5:4] = 2'b01;
        tick();
        req_model = ~req_model;
        check("c2a_grant", 32'(grant_id), 32'd2);
        check("c2a_mem_req", 32'(mem_req), 32'(req_model));
        check("c2a_l_n", 32'({mem_u_n, mem_l_n}), 32'b10);
        mem_ack = req_model;
        mem_q   = 16'h2222;
        tick();
        check("c2a_done", 32'(cli_done), 32'b100);
        check("c2a_cli_q", 32'(cli_q), 32'h2222);
        tick();
        check("c2a_done_gap", 32'(cli_done), 32'b000);
        tick();
        req_model = ~req_model;
        check("c2b_grant", 32'(grant_id), 32'd2);
        check("c2b_mem_req", 32'(mem_req), 32'(req_model));
        check("c2b_busy", 32'(busy), 32'd1);
        mem_ack = req_model;
        mem_q   = 16'h2223;
        tick();
        check("c2b_done", 32'(cli_done), 32'b100);
        check("c2b_cli_q", 32'(cli_q), 32'h2223);
        cli_req = 3'b000;
        tick();
        tick();

        // All three reading continuously: order 0,1,2,0,1,2
        cli_req = 3'b111;
        cli_we  = 3'b000;
        for (int k = 0; k < 6; k++) begin
            tick();
            req_model = ~req_model;
            check($sformatf("rr%0d_grant", k), 32'(grant_id), 32'(k % 3));
            check($sformatf("rr%0d_mem_req", k), 32'(mem_req), 32'(req_model));
            mem_ack = req_model;
            mem_q   = 16'h00AA + 16'((k % 3) * 16'h0011);
            tick();
            check($sformatf("rr%0d_done", k), 32'(cli_done), 32'(3'b001 << (k % 3)));
            check($sformatf("rr%0d_cli_q", k), 32'(cli_q), 32'(16'h00AA + 16'((k % 3) * 16'h0011)));
            tick();
        end
        cli_req = 3'b000;
        tick();

        // Ack withheld: timeout_err rises after TIMEOUT cycles in WAIT
        cli_req = 3'b001;
        tick();
        req_model = ~req_model;
        check("to_grant", 32'(grant_id), 32'd0);
        repeat (TIMEOUT - 1) tick();
        check("to_err_before", 32'(timeout_err), 32'd0);
        check("to_done_before", 32'(cli_done), 32'b000);
        tick();
        check("to_err_at", 32'(timeout_err), 32'd1);
        check("to_busy", 32'(busy), 32'd1);
        repeat (5) tick();
        check("to_no_done", 32'(cli_done), 32'b000);
        check("to_mem_req_once", 32'(mem_req), 32'(req_model));
        mem_ack = req_model;
        mem_q   = 16'h5555;
        tick();
        check("to_late_done", 32'(cli_done), 32'b001);
        check("to_late_cli_q", 32'(cli_q), 32'h5555);
        cli_req = 3'b000;
        tick();
        tick();
        check("to_err_sticky", 32'(timeout_err), 32'd1);

        // Reset while in WAIT
        cli_req = 3'b010;
        cli_a[1*AW +: AW] = 15'h0333;
        tick();
        req_model = ~req_model;
        check("rw_busy", 32'(busy), 32'd1);
        check("rw_mem_req", 32'(mem_req), 32'(req_model));
        reset = 1'b1;
        tick();
        check("rw_busy_rst", 32'(busy), 32'd0);
        check("rw_done_rst", 32'(cli_done), 32'b000);
        check("rw_resync", 32'(mem_req), 32'(mem_ack));
        check("rw_err_clr", 32'(timeout_err), 32'd0);
        check("rw_grant_rst", 32'(grant_id), 32'd0);
        reset = 1'b0;
        req_model = mem_ack;
        tick();
        req_model = ~req_model;
        check("rw_new_grant", 32'(grant_id), 32'd1);
        check("rw_new_mem_req", 32'(mem_req), 32'(req_model));
        check("rw_new_mem_a", 32'(mem_a), 32'h0333);
        mem_ack = req_model;
        mem_q   = 16'h6666;
        tick();
        check("rw_new_done", 32'(cli_done), 32'b010);
        check("rw_new_cli_q", 32'(cli_q), 32'h6666);
        cli_req = 3'b000;
        tick();
        tick();
        check("rw_final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
